// File: rtl/id_ctrl_hazard_if.sv
// -----------------------------------------------------------------------------
// id_ctrl_hazard_if
// Bundles every non-clock/reset signal of the decode control/hazard unit.
//   slave  : the unit itself (consumes ID/EX inputs, produces controls)
//   master : whoever drives IF/ID and EX status (pipeline or testbench)
// Inputs to the unit : inst_d, valid_d, rd_e, load_e, redirect_e
// Outputs of the unit: ALUSel, BSel, ASel, ILoad, WBSel, RegWEn, MemRW, PCSel,
//                      BrUn, rs1_d, rs2_d, rd_d, imm_d, stall_f, flush_ifid,
//                      illegal, stall_cnt, flush_cnt
// -----------------------------------------------------------------------------
interface id_ctrl_hazard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      inst_d;
  logic             valid_d;
  logic [4:0]       rd_e;
  logic             load_e;
  logic             redirect_e;

  logic [3:0]       ALUSel;
  logic [1:0]       BSel;
  logic [1:0]       ASel;
  logic [2:0]       ILoad;
  logic [1:0]       WBSel;
  logic             RegWEn;
  logic             MemRW;
  logic             PCSel;
  logic             BrUn;
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rd_d;
  logic [31:0]      imm_d;
  logic             stall_f;
  logic             flush_ifid;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output inst_d, valid_d, rd_e, load_e, redirect_e,
    input  ALUSel, BSel, ASel, ILoad, WBSel, RegWEn, MemRW, PCSel, BrUn,
           rs1_d, rs2_d, rd_d, imm_d, stall_f, flush_ifid, illegal,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  inst_d, valid_d, rd_e, load_e, redirect_e,
    output ALUSel, BSel, ASel, ILoad, WBSel, RegWEn, MemRW, PCSel, BrUn,
           rs1_d, rs2_d, rd_d, imm_d, stall_f, flush_ifid, illegal,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ctrl_hazard.sv
// -----------------------------------------------------------------------------
// id_ctrl_hazard
// Decode-stage control and hazard unit for an RV32I pipeline. Decodes the
// instruction in IF/ID into the ID/EX control bundle, detects load-use hazards
// (stall PC and IF/ID, inject a bubble) and sequences the post-redirect flush
// window. All control outputs are combinational; only the FSM, the sticky
// illegal flag and the saturating event counters are registered.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - id_ctrl_hazard_if.slave (decode inputs, EX status, controls, counters)
// Parameters:
//   FLUSH_CYC - IF/ID flush cycles after a redirect (>= 1)
//   CNT_W     - width of the performance counters
// -----------------------------------------------------------------------------
module id_ctrl_hazard #(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ctrl_hazard_if.slave  bus
);

  localparam int             FC_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYC - 1);

  typedef enum logic { RUN, FLUSH } state_e;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] bsel;
    logic [1:0] asel;
    logic [2:0] iload;
    logic [1:0] wb;
    logic       regwen;
    logic       memrw;
    logic       pcsel;
    logic       brun;
  } ctrl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU select from funct3; 'alt' picks SUB / SRA.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? 4'd1 : 4'd0;
      3'b001:  alu_of = 4'd2;
      3'b010:  alu_of = 4'd3;
      3'b011:  alu_of = 4'd4;
      3'b100:  alu_of = 4'd5;
      3'b101:  alu_of = alt ? 4'd7 : 4'd6;
      3'b110:  alu_of = 4'd8;
      default: alu_of = 4'd9;
    endcase
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;

  assign inst   = bus.inst_d;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  ctrl_t       dec;
  logic        known, use_rs1, use_rs2;
  logic [31:0] imm;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    dec     = '0;
    known   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm     = '0;
    case (opcode)
      OP_R: begin
        dec.alu = alu_of(f3, inst[30]);
        dec.wb = 2'd1; dec.regwen = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_IALU: begin
        // funct7[5] is immediate data except for the shift-right pair.
        dec.alu = alu_of(f3, inst[30] && (f3 == 3'b101));
        dec.bsel = 2'd1; dec.wb = 2'd1; dec.regwen = 1'b1;
        use_rs1 = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OP_LOAD: begin
        dec.bsel = 2'd1; dec.wb = 2'd0; dec.regwen = 1'b1; dec.iload = f3;
        use_rs1 = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        dec.bsel = 2'd1; dec.memrw = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        dec.asel = 2'd1; dec.bsel = 2'd1; dec.brun = f3[1];
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.asel = 2'd1; dec.bsel = 2'd1; dec.wb = 2'd2;
        dec.regwen = 1'b1; dec.pcsel = 1'b1;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.bsel = 2'd1; dec.wb = 2'd2; dec.regwen = 1'b1; dec.pcsel = 1'b1;
        use_rs1 = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OP_LUI: begin
        dec.asel = 2'd2; dec.bsel = 2'd1; dec.wb = 2'd1; dec.regwen = 1'b1;
        imm = {inst[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.asel = 2'd1; dec.bsel = 2'd1; dec.wb = 2'd1; dec.regwen = 1'b1;
        imm = {inst[31:12], 12'b0};
      end
      default: known = 1'b0;
    endcase
    if (rd == 5'd0) dec.regwen = 1'b0;
  end

  state_e           state_q;
  logic [FC_W-1:0]  fcnt_q;
  logic             illegal_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic  flushing, hazard, stall, issue;
  ctrl_t ctrl;

  // Priority: redirect/FLUSH > load-use > invalid/illegal > decode.
  // An invalid slot uses no registers, so it can never raise a stall.
  assign flushing = !rst && ((state_q == FLUSH) || bus.redirect_e);
  assign hazard   = bus.valid_d && bus.load_e && (bus.rd_e != 5'd0) &&
                    ((use_rs1 && (bus.rd_e == rs1)) || (use_rs2 && (bus.rd_e == rs2)));
  assign stall    = !rst && !flushing && hazard;
  assign issue    = !rst && !flushing && !hazard && bus.valid_d;
  assign ctrl     = issue ? dec : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.redirect_e) begin
        // A redirect restarts the window, from RUN or mid-FLUSH.
        fcnt_q  <= FC_RELOAD;
        state_q <= (FLUSH_CYC > 1) ? FLUSH : RUN;
      end else if (state_q == FLUSH) begin
        fcnt_q <= fcnt_q - FC_W'(1);
        if (fcnt_q <= FC_W'(1)) state_q <= RUN;
      end
      if (issue && !known) illegal_q <= 1'b1;
      if (stall && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flushing && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.ALUSel     = ctrl.alu;
  assign bus.BSel       = ctrl.bsel;
  assign bus.ASel       = ctrl.asel;
  assign bus.ILoad      = ctrl.iload;
  assign bus.WBSel      = ctrl.wb;
  assign bus.RegWEn     = ctrl.regwen;
  assign bus.MemRW      = ctrl.memrw;
  assign bus.PCSel      = ctrl.pcsel;
  assign bus.BrUn       = ctrl.brun;
  assign bus.rs1_d      = rs1;
  assign bus.rs2_d      = rs2;
  assign bus.rd_d       = rd;
  assign bus.imm_d      = imm;
  assign bus.stall_f    = stall;
  assign bus.flush_ifid = flushing;
  assign bus.illegal    = illegal_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ctrl_hazard.sv
// -----------------------------------------------------------------------------
// tb_id_ctrl_hazard
// Drives two instances with identical stimulus:
//   dut_a : FLUSH_CYC = 2, CNT_W = 16
//   dut_b : FLUSH_CYC = 1, CNT_W = 4
// Each step pushes the expected control bundle for both instances into
// scoreboard queues; the bundles are popped and compared half a cycle later.
// -----------------------------------------------------------------------------
module tb_id_ctrl_hazard;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] bsel;
    logic [1:0] asel;
    logic [2:0] iload;
    logic [1:0] wb;
    logic       regwen;
    logic       memrw;
    logic       pcsel;
    logic       brun;
    logic       stall;
    logic       flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ctrl_hazard_if #(.CNT_W(16)) bus_a ();
  id_ctrl_hazard_if #(.CNT_W(4))  bus_b ();

  id_ctrl_hazard #(.FLUSH_CYC(2), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  id_ctrl_hazard #(.FLUSH_CYC(1), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  exp_t obs_a, obs_b;
  assign obs_a = {bus_a.ALUSel, bus_a.BSel, bus_a.ASel, bus_a.ILoad, bus_a.WBSel,
                  bus_a.RegWEn, bus_a.MemRW, bus_a.PCSel, bus_a.BrUn,
                  bus_a.stall_f, bus_a.flush_ifid};
  assign obs_b = {bus_b.ALUSel, bus_b.BSel, bus_b.ASel, bus_b.ILoad, bus_b.WBSel,
                  bus_b.RegWEn, bus_b.MemRW, bus_b.PCSel, bus_b.BrUn,
                  bus_b.stall_f, bus_b.flush_ifid};

  int total = 0;
  int bad   = 0;

  exp_t  q_a[$];
  exp_t  q_b[$];
  logic [31:0] q_imm[$];
  string q_tag[$];

  localparam exp_t BUB = '0;
  localparam exp_t STL = 19'b1_0;
  localparam exp_t FLS = 19'b0_1;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] I_SW    = 32'h0020A423; // sw   x2,8(x1)
  localparam logic [31:0] I_LHU   = 32'h00C0D203; // lhu  x4,12(x1)
  localparam logic [31:0] I_BLTU  = 32'hFE20ECE3; // bltu x1,x2,-8
  localparam logic [31:0] I_SRAI  = 32'h40335293; // srai x5,x6,3
  localparam logic [31:0] I_ADDIN = 32'hC0000093; // addi x1,x0,-1024
  localparam logic [31:0] I_LUI   = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] I_JAL   = 32'h010000EF; // jal  x1,16
  localparam logic [31:0] I_JALR  = 32'h000280E7; // jalr x1,0(x5)
  localparam logic [31:0] I_AUIPC = 32'h00001397; // auipc x7,1
  localparam logic [31:0] I_X0    = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] I_ADD6  = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

  function automatic exp_t mk(input int alu, input int bsel, input int asel,
                              input int iload, input int wb, input bit rw,
                              input bit mw, input bit pc, input bit bu);
    exp_t e;
    e        = '0;
    e.alu    = 4'(alu);
    e.bsel   = 2'(bsel);
    e.asel   = 2'(asel);
    e.iload  = 3'(iload);
    e.wb     = 2'(wb);
    e.regwen = rw;
    e.memrw  = mw;
    e.pcsel  = pc;
    e.brun   = bu;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic valid, input logic [4:0] rde,
                       input logic loade, input logic redir);
    bus_a.inst_d = inst; bus_a.valid_d = valid; bus_a.rd_e = rde;
    bus_a.load_e = loade; bus_a.redirect_e = redir;
    bus_b.inst_d = inst; bus_b.valid_d = valid; bus_b.rd_e = rde;
    bus_b.load_e = loade; bus_b.redirect_e = redir;
  endtask

  // One cycle: drive, record expectations, compare at the falling edge,
  // then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [31:0] inst, input logic valid,
                      input logic [4:0] rde, input logic loade, input logic redir,
                      input exp_t ea, input exp_t eb, input logic [31:0] eimm);
    exp_t  xa, xb;
    logic [31:0] xi;
    string t;
    drive(inst, valid, rde, loade, redir);
    q_a.push_back(ea);
    q_b.push_back(eb);
    q_imm.push_back(eimm);
    q_tag.push_back(tag);
    @(negedge clk);
    xa = q_a.pop_front();
    xb = q_b.pop_front();
    xi = q_imm.pop_front();
    t  = q_tag.pop_front();
    check({t, "_ctrl_a"}, 32'(obs_a), 32'(xa));
    check({t, "_ctrl_b"}, 32'(obs_b), 32'(xb));
    check({t, "_imm"}, bus_a.imm_d, xi);
    @(posedge clk);
    #1;
  endtask

  exp_t E_ADD, E_SUB, E_SW, E_LHU, E_BLTU, E_SRAI, E_ADDI, E_LUI, E_JAL, E_JALR,
        E_AUIPC, E_X0;

  initial begin
    E_ADD   = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    E_SUB   = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    E_SW    = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
    E_LHU   = mk(0, 1, 0, 5, 0, 1, 0, 0, 0);
    E_BLTU  = mk(0, 1, 1, 0, 0, 0, 0, 0, 1);
    E_SRAI  = mk(7, 1, 0, 0, 1, 1, 0, 0, 0);
    E_ADDI  = mk(0, 1, 0, 0, 1, 1, 0, 0, 0);
    E_LUI   = mk(0, 1, 2, 0, 1, 1, 0, 0, 0);
    E_JAL   = mk(0, 1, 1, 0, 2, 1, 0, 1, 0);
    E_JALR  = mk(0, 1, 0, 0, 2, 1, 0, 1, 0);
    E_AUIPC = mk(0, 1, 1, 0, 1, 1, 0, 0, 0);
    E_X0    = mk(0, 1, 0, 0, 1, 0, 0, 0, 0);

    // Reset holds everything at bubble, even with hazard and redirect present.
    rst = 1'b1;
    drive(I_ADD, 1'b1, 5'd0, 1'b0, 1'b0);
    step("rst_add",   I_ADD,  1'b1, 5'd1, 1'b0, 1'b0, BUB, BUB, 32'h0);
    step("rst_haz",   I_ADD,  1'b1, 5'd1, 1'b1, 1'b1, BUB, BUB, 32'h0);
    check("rst_illegal",   32'(bus_a.illegal),   32'h0);
    check("rst_stall_cnt", 32'(bus_a.stall_cnt), 32'h0);
    check("rst_flush_cnt", 32'(bus_a.flush_cnt), 32'h0);
    rst = 1'b0;

    // Opcode sweep.
    step("add",   I_ADD,   1'b1, 5'd0, 1'b0, 1'b0, E_ADD,   E_ADD,   32'h0);
    check("add_fields", {17'b0, bus_a.rs1_d, bus_a.rs2_d, bus_a.rd_d}, {17'b0, 5'd1, 5'd2, 5'd3});
    step("sub",   I_SUB,   1'b1, 5'd0, 1'b0, 1'b0, E_SUB,   E_SUB,   32'h0);
    step("sw",    I_SW,    1'b1, 5'd0, 1'b0, 1'b0, E_SW,    E_SW,    32'h8);
    step("lhu",   I_LHU,   1'b1, 5'd0, 1'b0, 1'b0, E_LHU,   E_LHU,   32'hC);
    step("bltu",  I_BLTU,  1'b1, 5'd0, 1'b0, 1'b0, E_BLTU,  E_BLTU,  32'hFFFFFFF8);
    step("srai",  I_SRAI,  1'b1, 5'd0, 1'b0, 1'b0, E_SRAI,  E_SRAI,  32'h403);
    step("addin", I_ADDIN, 1'b1, 5'd0, 1'b0, 1'b0, E_ADDI,  E_ADDI,  32'hFFFFFC00);
    step("lui",   I_LUI,   1'b1, 5'd0, 1'b0, 1'b0, E_LUI,   E_LUI,   32'h12345000);
    step("jal",   I_JAL,   1'b1, 5'd0, 1'b0, 1'b0, E_JAL,   E_JAL,   32'h10);
    step("jalr",  I_JALR,  1'b1, 5'd0, 1'b0, 1'b0, E_JALR,  E_JALR,  32'h0);
    step("auipc", I_AUIPC, 1'b1, 5'd0, 1'b0, 1'b0, E_AUIPC, E_AUIPC, 32'h1000);
    step("x0",    I_X0,    1'b1, 5'd0, 1'b0, 1'b0, E_X0,    E_X0,    32'h1);
    step("inval", I_ADD,   1'b0, 5'd1, 1'b1, 1'b0, BUB,     BUB,     32'h0);

    // Load-use.
    step("lu_rs1",  I_ADD6, 1'b1, 5'd5, 1'b1, 1'b0, STL,   STL,   32'h0);
    check("lu_cnt1", 32'(bus_a.stall_cnt), 32'd1);
    step("lu_rd0",  I_ADD6, 1'b1, 5'd0, 1'b1, 1'b0, E_ADD, E_ADD, 32'h0);
    step("lu_lui",  I_LUI,  1'b1, 5'd5, 1'b1, 1'b0, E_LUI, E_LUI, 32'h12345000);
    step("lu_rs2",  I_ADD6, 1'b1, 5'd7, 1'b1, 1'b0, STL,   STL,   32'h0);
    check("lu_cnt2", 32'(bus_a.stall_cnt), 32'd2);

    // Single redirect: two flush cycles on A, one on B.
    step("rd1", I_ADD, 1'b1, 5'd0, 1'b0, 1'b1, FLS,   FLS,   32'h0);
    step("rd2", I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, FLS,   E_ADD, 32'h0);
    step("rd3", I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, E_ADD, E_ADD, 32'h0);
    check("rd_fcnt_a", 32'(bus_a.flush_cnt), 32'd2);
    check("rd_fcnt_b", 32'(bus_b.flush_cnt), 32'd1);

    // Redirect together with load-use: flush wins, no stall counted.
    step("sim1", I_ADD6, 1'b1, 5'd5, 1'b1, 1'b1, FLS,   FLS,   32'h0);
    step("sim2", I_ADD6, 1'b1, 5'd5, 1'b1, 1'b0, FLS,   STL,   32'h0);
    step("sim3", I_ADD6, 1'b1, 5'd5, 1'b0, 1'b0, E_ADD, E_ADD, 32'h0);
    check("sim_scnt_a", 32'(bus_a.stall_cnt), 32'd2);
    check("sim_fcnt_a", 32'(bus_a.flush_cnt), 32'd4);
    check("sim_scnt_b", 32'(bus_b.stall_cnt), 32'd3);

    // Redirect inside FLUSH reloads the window.
    step("rl1", I_ADD, 1'b1, 5'd0, 1'b0, 1'b1, FLS,   FLS,   32'h0);
    step("rl2", I_ADD, 1'b1, 5'd0, 1'b0, 1'b1, FLS,   FLS,   32'h0);
    step("rl3", I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, FLS,   E_ADD, 32'h0);
    step("rl4", I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, E_ADD, E_ADD, 32'h0);
    check("rl_fcnt_a", 32'(bus_a.flush_cnt), 32'd7);
    check("rl_fcnt_b", 32'(bus_b.flush_cnt), 32'd4);

    // Squashed or invalid unknown opcodes are not recorded as illegal.
    step("sq1", I_BAD, 1'b1, 5'd0, 1'b0, 1'b1, FLS,   FLS,   32'h0);
    step("sq2", I_BAD, 1'b0, 5'd0, 1'b0, 1'b0, FLS,   BUB,   32'h0);
    step("sq3", I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, E_ADD, E_ADD, 32'h0);
    check("sq_illegal_a", 32'(bus_a.illegal), 32'h0);
    check("sq_illegal_b", 32'(bus_b.illegal), 32'h0);

    // Illegal opcode: bubble, sticky flag.
    step("il1", I_BAD, 1'b1, 5'd0, 1'b0, 1'b0, BUB,   BUB,   32'h0);
    step("il2", I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, E_ADD, E_ADD, 32'h0);
    check("il_sticky_a", 32'(bus_a.illegal), 32'h1);
    check("il_sticky_b", 32'(bus_b.illegal), 32'h1);

    // Reset in the middle of a flush window.
    step("rs_redir", I_ADD, 1'b1, 5'd0, 1'b0, 1'b1, FLS, FLS, 32'h0);
    rst = 1'b1;
    step("rs_hold",  I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, BUB, BUB, 32'h0);
    check("rs_illegal", 32'(bus_a.illegal),   32'h0);
    check("rs_scnt",    32'(bus_a.stall_cnt), 32'h0);
    check("rs_fcnt",    32'(bus_a.flush_cnt), 32'h0);
    rst = 1'b0;
    step("rs_run",   I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, E_ADD, E_ADD, 32'h0);

    // Saturation: B's 4-bit stall counter sticks at 15.
    for (int i = 0; i < 20; i++)
      step("sat", I_ADD6, 1'b1, 5'd5, 1'b1, 1'b0, STL, STL, 32'h0);
    check("sat_scnt_b", 32'(bus_b.stall_cnt), 32'd15);
    check("sat_scnt_a", 32'(bus_a.stall_cnt), 32'd20);
    check("sat_fcnt_b", 32'(bus_b.flush_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ctrl_hazard.md
# id_ctrl_hazard

Decode-stage control and hazard unit. It turns the RV32I instruction held in IF/ID into the control bundle latched by the ID/EX control register: ALUSel, BSel, ILoad, WBSel, RegWEn, MemRW, PCSel, ASel and BrUn. It also detects load-use hazards and sequences the post-redirect flush window. Its outputs drive IF (PC hold), the IF/ID register (hold/flush) and the ID/EX register inputs directly.

## Interface
- FLUSH_CYC, 2, cycles of IF/ID flush after a redirect (≥1; 2 covers synchronous IMEM latency)
- CNT_W, 16, width of performance counters
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- inst_d  in  32  instruction in ID
- valid_d  in  1  inst_d is valid
- rd_e  in  5  destination register of instruction in EX
- load_e  in  1  instruction in EX is a load
- redirect_e  in  1  EX redirects PC (taken branch/jump)
- ALUSel  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- BSel  out  2  0 rs2, 1 imm
- ASel  out  2  0 rs1, 1 PC, 2 zero
- ILoad  out  3  load funct3 (loads only, else 0)
- WBSel  out  2  0 mem, 1 ALU, 2 PC+4
- RegWEn, MemRW (1 = write), PCSel, BrUn  out  1 each
- rs1_d, rs2_d, rd_d  out  5  register fields of inst_d
- imm_d  out  32  sign-extended immediate per I/S/B/U/J format, 0 for R-type
- stall_f  out  1  hold PC and IF/ID
- flush_ifid  out  1  clear IF/ID on next edge
- illegal  out  1  sticky: unknown opcode decoded
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- **Bubble.** All control outputs are 0. This equals the ID/EX reset value.
- **Decode** (when valid, state RUN, not suppressed):
  - R (0110011): ALU from funct3/funct7[5]; ASel 0; BSel 0; WB 1; RegWEn 1.
  - I-ALU (0010011): BSel 1; funct7[5] selects SRA only when funct3 = 101; never SUB.
  - Load (0000011): ADD; BSel 1; WB 0; RegWEn 1; ILoad = funct3.
  - Store (0100011): ADD; BSel 1; MemRW 1.
  - Branch (1100011): ASel 1; BSel 1; ADD; BrUn = funct3[1].
  - JAL (1101111): ASel 1; BSel 1; WB 2; RegWEn 1; PCSel 1.
  - JALR (1100111): ASel 0; BSel 1; WB 2; RegWEn 1; PCSel 1.
  - LUI (0110111): ASel 2; BSel 1; WB 1; RegWEn 1.
  - AUIPC (0010111): ASel 1; BSel 1; WB 1; RegWEn 1.
  - RegWEn is forced to 0 when rd = 0.
  - Any other opcode: bubble, and illegal is set.
- **rs usage.**
  - rs1 is used by R, I-ALU, load, store, branch and JALR.
  - rs2 is used by R, store and branch.
- **Load-use.** Hazard = load_e & rd_e ≠ 0 & rd_e equals a used rs of inst_d.
  - Response: stall_f = 1 and bubble output.
  - Counts one stall_cnt per cycle.
- **FSM states: RUN, FLUSH.** Down-counter fcnt.
  - RUN + redirect_e:
    - bubble, flush_ifid = 1, flush_cnt++.
    - Load fcnt = FLUSH_CYC−1.
    - Go to FLUSH if fcnt > 0, else stay in RUN.
  - FLUSH: bubble, flush_ifid = 1, flush_cnt++, fcnt−−; return to RUN when fcnt reaches 0.
  - redirect_e in FLUSH reloads fcnt = FLUSH_CYC−1.
- **Priority:** redirect/FLUSH > load-use > invalid/illegal > decode.
  - In FLUSH, load-use is ignored and stall_f = 0.
  - Illegal is only recorded when the instruction is not squashed.
- **Invalid.** valid_d = 0 gives a bubble with no stall.
- **Counters** stop at all-ones.

## Timing
- Control outputs, register fields, imm_d, stall_f and flush_ifid are combinational from inst_d, the EX inputs and state, with zero latency.
- state, fcnt, illegal and the counters update on posedge clk.
- **Reset** (asynchronous, held while rst = 1):
  - state RUN, fcnt 0, illegal 0, counters 0.
  - Control outputs forced to bubble.
  - stall_f = 0, flush_ifid = 0.
- Reset mid-FLUSH aborts the window; the first cycle after reset is RUN.
- A load-use stall lasts exactly one cycle: next cycle the load is in MEM and EX holds the bubble.
- Simultaneous redirect_e and load-use: flush only, stall_f = 0, stall_cnt unchanged.

## Test plan
- **Full opcode sweep.** Apply each opcode with valid_d = 1.
  - add x3,x1,x2 → ALUSel 0, BSel 0, WBSel 1, RegWEn 1.
  - sw → MemRW 1, RegWEn 0, BSel 1.
  - lhu → ILoad 5, WBSel 0.
  - bltu → BrUn 1, ASel 1.
  - srai → ALUSel 7.
  - lui → ASel 2.
- **Load-use.** load_e = 1, rd_e = 5, inst_d = add x6,x5,x7.
  - Expect stall_f = 1, bubble, stall_cnt 0→1.
  - Repeat with rd_e = 0 → no stall.
  - Repeat with lui x5 in ID → no stall (rs not used).
- **Redirect with FLUSH_CYC = 2.** Pulse redirect_e for one cycle.
  - Expect flush_ifid = 1 for 2 cycles and bubbles, then decode resumes.
  - flush_cnt = 2.
  - With FLUSH_CYC = 1: a single flush cycle.
- **Simultaneous redirect + load-use.**
  - Expect flush_ifid = 1, stall_f = 0.
  - stall_cnt unchanged.
- **Illegal and reset.**
  - inst_d = 32'hFFFFFFFF → bubble; illegal rises and stays high.
  - Assert rst mid-FLUSH → illegal 0, counters 0, RUN state.
  - Write to x0 (addi x0,x0,1) → RegWEn 0.
- **Counter saturation.** With CNT_W = 4, hold a load-use hazard for 20 cycles → stall_cnt sticks at 15.
